// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default width
// for the multicycle execute-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_component.sv
// Iterative shift-add unsigned multiplier, one bit per step.
// Ports: clock, reset, load, step, a, b -> fin, lo (+hi_nz under ALU_OVERFLOW_FLAG_EN).
module shift_add_multiplier_component
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_FLAG_EN
  , output logic           hi_nz
`endif
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;

  // Upper-half add keeps its carry, then the
  // whole product shifts right by one.
  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (mplier_q[0])
      sum = sum + {1'b0, mcand_q};
    prod_d = {sum, prod_q[WIDTH-1:1]};
  end

  // lo comes from prod_d: the final step's
  // result is written out on the same edge.
  assign fin = step && (cnt_q == CW'(WIDTH-1));
  assign lo  = prod_d[WIDTH-1:0];
`ifdef ALU_OVERFLOW_FLAG_EN
  assign hi_nz = |prod_d[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= a;
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      prod_q   <= prod_d;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_multicycle_component.sv
// Execute-stage ALU: 1-edge logic/arith/shift, WIDTH-edge multiply.
// Ports: clock, reset, in_a, in_b, op, start -> out, busy, done, zero (+ovf under ALU_OVERFLOW_FLAG_EN).
module alu_multicycle_component
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             zero
`ifdef ALU_OVERFLOW_FLAG_EN
  , output logic           ovf
`endif
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] alu_r;
  logic [SW-1:0]    shamt;
  logic             mul_load;
  logic             mul_step;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_lo;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic             mul_hi_nz;
  logic             alu_v;
`endif

  assign shamt = in_b[SW-1:0];

  always_comb begin
    alu_r = '0;
    unique case (op)
      ALU_ADD: alu_r = in_a + in_b;
      ALU_SUB: alu_r = in_a - in_b;
      ALU_AND: alu_r = in_a & in_b;
      ALU_OR:  alu_r = in_a | in_b;
      ALU_XOR: alu_r = in_a ^ in_b;
      ALU_SLL: alu_r = in_a << shamt;
      ALU_SRL: alu_r = in_a >> shamt;
      ALU_MUL: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  // Signed overflow: operand signs (b inverted
  // for sub) agree but the result sign differs.
  always_comb begin
    alu_v = 1'b0;
    unique case (op)
      ALU_ADD: alu_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != in_a[WIDTH-1]);
      ALU_SUB: alu_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                       (alu_r[WIDTH-1] != in_a[WIDTH-1]);
      default: alu_v = 1'b0;
    endcase
  end
`endif

  assign mul_load = (state_q == ST_IDLE) && start &&
                    (op == ALU_MUL);
  assign mul_step = (state_q == ST_MUL);

  shift_add_multiplier_component #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock (clock),
    .reset (reset),
    .load  (mul_load),
    .step  (mul_step),
    .a     (in_a),
    .b     (in_b),
    .fin   (mul_fin),
    .lo    (mul_lo)
`ifdef ALU_OVERFLOW_FLAG_EN
    , .hi_nz (mul_hi_nz)
`endif
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op == ALU_MUL) begin
              busy    <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              out  <= alu_r;
              zero <= (alu_r == '0);
              done <= 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
              ovf  <= alu_v;
`endif
            end
          end
        end
        ST_MUL: begin
          if (mul_fin) begin
            out     <= mul_lo;
            zero    <= (mul_lo == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
`ifdef ALU_OVERFLOW_FLAG_EN
            ovf     <= mul_hi_nz;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_component.sv
// Bench for alu_multicycle_component: directed literal
// checks plus random traffic against a behavioural model.
module tb_alu_multicycle_component;

  logic        clock;
  logic        reset;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  op;
  logic        start;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        zero;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  alu_multicycle_component dut (
    .clock (clock),
    .reset (reset),
    .in_a  (in_a),
    .in_b  (in_b),
    .op    (op),
    .start (start),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
`ifdef ALU_OVERFLOW_FLAG_EN
    , .ovf (ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: results from plain integer math,
  // a multiply simply completes 16 edges after it starts.
  bit [15:0] m_out;
  bit        m_busy, m_done, m_zero, m_ovf;
  int        m_left;
  bit [15:0] m_a, m_b;

  function automatic void ref_op(input bit [2:0] o,
      input bit [15:0] a, input bit [15:0] b,
      output bit [15:0] r, output bit v);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    v = 0;
    case (o)
      3'd0: begin s = sa + sb; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; v = (s > 32767) || (s < -32768); end
      default: s = 0;
    endcase
    case (o)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: r = 0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_out = 0; m_busy = 0; m_done = 0;
      m_zero = 0; m_ovf = 0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        bit [31:0] p;
        p = {16'h0, m_a} * {16'h0, m_b};
        m_out = p[15:0];
        m_zero = (p[15:0] == 0);
        m_ovf = (p[31:16] != 0);
        m_done = 1;
        m_busy = 0;
      end else m_done = 0;
    end else if (start) begin
      if (op == 3'd7) begin
        m_busy = 1; m_left = 16;
        m_a = in_a; m_b = in_b;
        m_done = 0;
      end else begin
        bit [15:0] r;
        bit v;
        ref_op(op, in_a, in_b, r, v);
        m_out = r; m_zero = (r == 0);
        m_ovf = v; m_done = 1;
      end
    end else m_done = 0;
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clock) begin
    chk("cyc_out", {16'h0, out}, {16'h0, m_out});
    chk("cyc_busy", {31'h0, busy}, {31'h0, m_busy});
    chk("cyc_done", {31'h0, done}, {31'h0, m_done});
    chk("cyc_zero", {31'h0, zero}, {31'h0, m_zero});
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("cyc_ovf", {31'h0, ovf}, {31'h0, m_ovf});
`endif
  end

  // One-cycle request; returns #1 after the start edge.
  task automatic issue(input bit [2:0] o, input bit [15:0] a,
                       input bit [15:0] b);
    @(posedge clock); #1;
    op = o; in_a = a; in_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges until done; optionally disturbs the
  // inputs at edge 'inj' to show they are ignored.
  task automatic wait_done(input int inj, output int n,
                           output int nb);
    n = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      n++;
      if (start) start = 1'b0;
      if (n == inj) begin
        start = 1'b1; op = 3'd0;
        in_a = 16'hFFFF; in_b = 16'h0001;
      end
      if (done) break;
      if (busy) nb++;
    end
    start = 1'b0;
    if (!done)
      chk("mul_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int n, nb;
    reset = 1'b1; start = 0; op = 0;
    in_a = 0; in_b = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out", {16'h0, out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;

    issue(3'd0, 16'h7FFF, 16'h0001);
    chk("add_out", {16'h0, out}, 32'h8000);
    chk("add_done", {31'h0, done}, 32'h1);
    chk("add_zero", {31'h0, zero}, 32'h0);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("add_ovf", {31'h0, ovf}, 32'h1);
`endif
    @(posedge clock); #1;
    chk("add_done_pulse", {31'h0, done}, 32'h0);

    issue(3'd1, 16'h0005, 16'h0005);
    chk("sub_out", {16'h0, out}, 32'h0);
    chk("sub_zero", {31'h0, zero}, 32'h1);
    issue(3'd5, 16'h0001, 16'h0013);
    chk("sll_out", {16'h0, out}, 32'h0008);
    issue(3'd6, 16'h8000, 16'h000F);
    chk("srl_out", {16'h0, out}, 32'h0001);

    issue(3'd7, 16'h0012, 16'h0034);
    chk("mul_busy0", {31'h0, busy}, 32'h1);
    wait_done(0, n, nb);
    chk("mul_lat", n, 16);
    chk("mul_busy_cyc", nb, 15);
    chk("mul_out", {16'h0, out}, 32'h03A8);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("mul_ovf", {31'h0, ovf}, 32'h0);
`endif

    issue(3'd7, 16'h0100, 16'h0100);
    wait_done(0, n, nb);
    chk("mul2_out", {16'h0, out}, 32'h0);
    chk("mul2_zero", {31'h0, zero}, 32'h1);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("mul2_ovf", {31'h0, ovf}, 32'h1);
`endif

    issue(3'd7, 16'h0012, 16'h0034);
    wait_done(4, n, nb);
    chk("mul3_lat", n, 16);
    chk("mul3_out", {16'h0, out}, 32'h03A8);
    @(posedge clock); #1;
    chk("mul3_single_done", {31'h0, done}, 32'h0);

    issue(3'd7, 16'h0012, 16'h0034);
    repeat (7) @(posedge clock);
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("abort_out", {16'h0, out}, 32'h0);
    chk("abort_busy0", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_zero", {31'h0, zero}, 32'h0);
    #1 reset = 1'b0;
    issue(3'd0, 16'h0002, 16'h0003);
    chk("post_add", {16'h0, out}, 32'h0005);
    chk("post_done", {31'h0, done}, 32'h1);

    @(posedge clock); #1;
    in_a = 16'hF0F0; in_b = 16'h0FF0;
    op = 3'd2; start = 1'b1;
    @(posedge clock); #1;
    chk("b2b_and", {16'h0, out}, 32'h00F0);
    chk("b2b_done1", {31'h0, done}, 32'h1);
    op = 3'd3;
    @(posedge clock); #1;
    chk("b2b_or", {16'h0, out}, 32'hFFF0);
    chk("b2b_done2", {31'h0, done}, 32'h1);
    op = 3'd4;
    @(posedge clock); #1;
    chk("b2b_xor", {16'h0, out}, 32'hFF00);
    chk("b2b_done3", {31'h0, done}, 32'h1);
    start = 1'b0;

    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 249) == 0);
      start = ($urandom_range(0, 9) < 6);
      op = 3'($urandom_range(0, 7));
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) in_b = in_a;
      if ($urandom_range(0, 7) == 0) in_a = 16'h7FFF;
    end
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
